// File: rtl/current_memory_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tetris : shared tile types, board coordinates and shape offset helpers   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package tetris;

  localparam int c_coord_w = 8;

  typedef enum logic [2:0] {
    eNon = 3'd0,
    eI   = 3'd1,
    eO   = 3'd2,
    eT   = 3'd3,
    eS   = 3'd4,
    eZ   = 3'd5,
    eJ   = 3'd6,
    eL   = 3'd7
  } tile_type_e;

  typedef struct packed {
    logic [c_coord_w-1:0] x;
    logic [c_coord_w-1:0] y;
  } point_t;

  typedef logic signed [2:0] offset_t;

  typedef struct packed {
    offset_t dx;
    offset_t dy;
  } cell_offset_t;

  typedef cell_offset_t [3:0] shape_t;

  function automatic cell_offset_t mk_off(input int dx, input int dy);
    cell_offset_t o;
    o.dx = offset_t'(dx);
    o.dy = offset_t'(dy);
    return o;
  endfunction

  // Angle-0 footprint; rotatable shapes stay within -1..1 so rotation never overflows.
  function automatic shape_t base_shape(input tile_type_e t);
    shape_t s;
    s = '0;
    case (t)
      eI: begin s[0] = mk_off( 0, 0); s[1] = mk_off(1, 0); s[2] = mk_off( 2, 0); s[3] = mk_off(3, 0); end
      eO: begin s[0] = mk_off( 0, 0); s[1] = mk_off(1, 0); s[2] = mk_off( 0, 1); s[3] = mk_off(1, 1); end
      eT: begin s[0] = mk_off(-1, 0); s[1] = mk_off(0, 0); s[2] = mk_off( 1, 0); s[3] = mk_off(0, 1); end
      eS: begin s[0] = mk_off( 0, 0); s[1] = mk_off(1, 0); s[2] = mk_off(-1, 1); s[3] = mk_off(0, 1); end
      eZ: begin s[0] = mk_off(-1, 0); s[1] = mk_off(0, 0); s[2] = mk_off( 0, 1); s[3] = mk_off(1, 1); end
      eJ: begin s[0] = mk_off(-1, 0); s[1] = mk_off(0, 0); s[2] = mk_off( 1, 0); s[3] = mk_off(1, 1); end
      eL: begin s[0] = mk_off(-1, 0); s[1] = mk_off(0, 0); s[2] = mk_off( 1, 0); s[3] = mk_off(-1, 1); end
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic cell_offset_t rotate(input cell_offset_t o, input logic [1:0] angle);
    cell_offset_t r;
    case (angle)
      2'd1:    begin r.dx = -o.dy; r.dy =  o.dx; end
      2'd2:    begin r.dx = -o.dx; r.dy = -o.dy; end
      2'd3:    begin r.dx =  o.dy; r.dy = -o.dx; end
      default: r = o;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/current_memory_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | current_memory_if : executor <-> current-tile memory bus                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface current_memory_if;
  import tetris::*;

  logic             set_v_i;
  tile_type_e       type_i;
  logic [1:0]       angle_i;
  logic             pos_v_i;
  point_t           pos_i;

  tile_type_e       type_o;
  logic [1:0]       angle_o;
  point_t           pos_o;
  logic             is_ready_o;
  point_t [3:0]     cells_o;
  logic             cells_v_o;
  logic             oob_o;

  modport master (
    output set_v_i, type_i, angle_i, pos_v_i, pos_i,
    input  type_o, angle_o, pos_o, is_ready_o, cells_o, cells_v_o, oob_o
  );

  modport slave (
    input  set_v_i, type_i, angle_i, pos_v_i, pos_i,
    output type_o, angle_o, pos_o, is_ready_o, cells_o, cells_v_o, oob_o
  );

endinterface
`default_nettype wire

// File: rtl/current_memory_tile_shape_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tile_shape_rom : combinational cell offset lookup by type/angle/index    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tile_shape_rom
  import tetris::*;
(
  input  tile_type_e tile,
  input  logic [1:0] angle,
  input  logic [1:0] idx,
  output offset_t    dx,
  output offset_t    dy
);

  shape_t       w_shape;
  cell_offset_t w_base;
  cell_offset_t w_off;

  // The I bar only has two distinct orientations; O is rotation invariant.
  always_comb begin
    w_shape = base_shape(tile);
    w_base  = w_shape[idx];
    w_off   = w_base;
    case (tile)
      eI: begin
        if (angle[0]) begin
          w_off.dx = w_base.dy;
          w_off.dy = w_base.dx;
        end
      end
      eO, eNon: w_off = w_base;
      default:  w_off = rotate(w_base, angle);
    endcase
  end

  assign dx = w_off.dx;
  assign dy = w_off.dy;

endmodule
`default_nettype wire

// File: rtl/current_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | current_memory : stored tile plus 4-cycle expansion to board cells       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module current_memory
  import tetris::*;
#(
  parameter int width_p  = 16,
  parameter int height_p = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  current_memory_if.slave  bus
);

  typedef enum logic [0:0] {
    eIDLE   = 1'b0,
    eExpand = 1'b1
  } state_e;

  localparam int c_sum_w = c_coord_w + 2;
  localparam logic signed [c_sum_w-1:0] c_width_s  = c_sum_w'(width_p);
  localparam logic signed [c_sum_w-1:0] c_height_s = c_sum_w'(height_p);

  state_e       r_state;
  tile_type_e   r_type;
  logic [1:0]   r_angle;
  point_t       r_pos;
  point_t [3:0] r_cells;
  logic         r_cells_v;
  logic         r_oob;
  logic         r_ready;
  logic [1:0]   r_idx;

  offset_t                    w_dx;
  offset_t                    w_dy;
  logic signed [c_sum_w-1:0]  w_sum_x;
  logic signed [c_sum_w-1:0]  w_sum_y;
  logic                       w_cell_oob;
  logic                       w_accept;

  tile_shape_rom u_rom (
    .tile  (r_type),
    .angle (r_angle),
    .idx   (r_idx),
    .dx    (w_dx),
    .dy    (w_dy)
  );

  // Two guard bits keep both negative sums and overshoots past the board visible.
  assign w_sum_x = $signed({2'b00, r_pos.x}) + $signed({{(c_sum_w-3){w_dx[2]}}, w_dx});
  assign w_sum_y = $signed({2'b00, r_pos.y}) + $signed({{(c_sum_w-3){w_dy[2]}}, w_dy});

  assign w_cell_oob = w_sum_x[c_sum_w-1] | w_sum_y[c_sum_w-1] |
                      (w_sum_x >= c_width_s) | (w_sum_y >= c_height_s);

  assign w_accept = bus.set_v_i | bus.pos_v_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= eIDLE;
      r_type    <= eNon;
      r_angle   <= 2'd0;
      r_pos     <= '0;
      r_cells   <= '0;
      r_cells_v <= 1'b0;
      r_oob     <= 1'b0;
      r_ready   <= 1'b1;
      r_idx     <= 2'd0;
    end else begin
      case (r_state)
        eIDLE: begin
          if (w_accept) begin
            if (bus.set_v_i) begin
              r_type  <= bus.type_i;
              r_angle <= bus.angle_i;
            end
            if (bus.pos_v_i) begin
              r_pos <= bus.pos_i;
            end
            r_idx     <= 2'd0;
            r_cells_v <= 1'b0;
            r_oob     <= 1'b0;
            r_ready   <= 1'b0;
            r_state   <= eExpand;
          end
        end
        eExpand: begin
          r_cells[r_idx].x <= w_sum_x[c_coord_w-1:0];
          r_cells[r_idx].y <= w_sum_y[c_coord_w-1:0];
          r_idx            <= r_idx + 2'd1;
          // An empty tile occupies nothing, so it can never be out of bounds.
          if (r_type != eNon) begin
            r_oob <= r_oob | w_cell_oob;
          end
          if (r_idx == 2'd3) begin
            r_state   <= eIDLE;
            r_ready   <= 1'b1;
            r_cells_v <= (r_type != eNon);
          end
        end
        default: r_state <= eIDLE;
      endcase
    end
  end

  assign bus.type_o     = r_type;
  assign bus.angle_o    = r_angle;
  assign bus.pos_o      = r_pos;
  assign bus.is_ready_o = r_ready;
  assign bus.cells_o    = r_cells;
  assign bus.cells_v_o  = r_cells_v;
  assign bus.oob_o      = r_oob;

endmodule
`default_nettype wire

// File: tb/tb_current_memory.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_current_memory : scoreboard bench for current_memory                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_current_memory;
  import tetris::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  current_memory_if bus();

  current_memory #(.width_p(16), .height_p(32)) u_dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  typedef struct {
    string        name;
    tile_type_e   t;
    logic [1:0]   a;
    point_t       p;
    point_t [3:0] c;
    logic         cv;
    logic         oob;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic point_t pt(input int x, input int y);
    point_t r;
    r.x = 8'(x);
    r.y = 8'(y);
    return r;
  endfunction

  function automatic exp_t mk(input string n, input tile_type_e t, input logic [1:0] a,
                              input point_t p, input logic cv, input logic oob,
                              input point_t c0, input point_t c1, input point_t c2, input point_t c3);
    exp_t e;
    e.name = n; e.t = t; e.a = a; e.p = p; e.cv = cv; e.oob = oob;
    e.c[0] = c0; e.c[1] = c1; e.c[2] = c2; e.c[3] = c3;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_type"},  64'(bus.type_o), 64'(eNon));
    check({tag, "_angle"}, 64'(bus.angle_o), 64'd0);
    check({tag, "_pos"},   64'(bus.pos_o), 64'd0);
    check({tag, "_cells"}, 64'(bus.cells_o), 64'd0);
    check({tag, "_cv"},    64'(bus.cells_v_o), 64'd0);
    check({tag, "_oob"},   64'(bus.oob_o), 64'd0);
    check({tag, "_ready"}, 64'(bus.is_ready_o), 64'd1);
  endtask

  // Monitor: each rising is_ready_o completes one expansion.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n && bus.is_ready_o === 1'b1 && prev === 1'b0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got ready rise expected none");
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_type"},  64'(bus.type_o), 64'(e.t));
          check({e.name, "_angle"}, 64'(bus.angle_o), 64'(e.a));
          check({e.name, "_pos"},   64'(bus.pos_o), 64'(e.p));
          check({e.name, "_cv"},    64'(bus.cells_v_o), 64'(e.cv));
          check({e.name, "_oob"},   64'(bus.oob_o), 64'(e.oob));
          if (e.cv) check({e.name, "_cells"}, 64'(bus.cells_o), 64'(e.c));
        end
      end
      prev = bus.is_ready_o;
    end
  end

  // Drives one request; optionally fires an ignored request two cycles into the expansion.
  task automatic request(input logic sv, input tile_type_e t, input logic [1:0] a,
                         input logic pv, input point_t p, input logic inject, input exp_t e);
    @(negedge clk);
    bus.set_v_i = sv; bus.type_i = t; bus.angle_i = a;
    bus.pos_v_i = pv; bus.pos_i = p;
    sb_q.push_back(e);
    @(negedge clk);
    bus.set_v_i = 1'b0; bus.pos_v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_busy%0d", e.name, k), 64'(bus.is_ready_o), 64'd0);
      check($sformatf("%s_hold%0d", e.name, k), 64'(bus.angle_o), 64'(e.a));
      if (inject && k == 1) begin
        bus.set_v_i = 1'b1; bus.type_i = eL; bus.angle_i = 2'd3;
      end else begin
        bus.set_v_i = 1'b0;
      end
      if (k < 3) @(negedge clk);
    end
    bus.set_v_i = 1'b0;
    @(negedge clk);
    check({e.name, "_ready"}, 64'(bus.is_ready_o), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  point_t dc;

  initial begin : stim
    dc = pt(0, 0);
    bus.set_v_i = 1'b0; bus.type_i = eNon; bus.angle_i = 2'd0;
    bus.pos_v_i = 1'b0; bus.pos_i = '0;
    #12;
    check_reset("por");
    @(negedge clk);
    reset_n = 1'b1;

    request(1'b0, eNon, 2'd0, 1'b1, pt(5, 10), 1'b0,
            mk("pos_only", eNon, 2'd0, pt(5, 10), 1'b0, 1'b0, dc, dc, dc, dc));
    request(1'b1, eI, 2'd0, 1'b0, pt(0, 0), 1'b0,
            mk("basic_i", eI, 2'd0, pt(5, 10), 1'b1, 1'b0, pt(5, 10), pt(6, 10), pt(7, 10), pt(8, 10)));
    request(1'b1, eI, 2'd0, 1'b1, pt(14, 0), 1'b0,
            mk("right_oob", eI, 2'd0, pt(14, 0), 1'b1, 1'b1, pt(14, 0), pt(15, 0), pt(16, 0), pt(17, 0)));
    request(1'b1, eT, 2'd0, 1'b1, pt(0, 5), 1'b0,
            mk("left_oob", eT, 2'd0, pt(0, 5), 1'b1, 1'b1, pt(255, 5), pt(0, 5), pt(1, 5), pt(0, 6)));
    request(1'b1, eO, 2'd0, 1'b1, pt(14, 30), 1'b0,
            mk("corner_in", eO, 2'd0, pt(14, 30), 1'b1, 1'b0, pt(14, 30), pt(15, 30), pt(14, 31), pt(15, 31)));
    request(1'b0, eNon, 2'd0, 1'b1, pt(15, 30), 1'b0,
            mk("corner_out", eO, 2'd0, pt(15, 30), 1'b1, 1'b1, pt(15, 30), pt(16, 30), pt(15, 31), pt(16, 31)));
    request(1'b1, eI, 2'd1, 1'b1, pt(3, 4), 1'b0,
            mk("i_vert", eI, 2'd1, pt(3, 4), 1'b1, 1'b0, pt(3, 4), pt(3, 5), pt(3, 6), pt(3, 7)));
    request(1'b1, eT, 2'd1, 1'b0, pt(0, 0), 1'b1,
            mk("busy_drop", eT, 2'd1, pt(3, 4), 1'b1, 1'b0, pt(3, 3), pt(3, 4), pt(3, 5), pt(2, 4)));
    request(1'b1, eI, 2'd3, 1'b1, pt(5, 5), 1'b0,
            mk("angle3", eI, 2'd3, pt(5, 5), 1'b1, 1'b0, pt(5, 5), pt(5, 6), pt(5, 7), pt(5, 8)));
    request(1'b1, eNon, 2'd2, 1'b0, pt(0, 0), 1'b0,
            mk("non_write", eNon, 2'd2, pt(5, 5), 1'b0, 1'b0, dc, dc, dc, dc));

    // Reset two edges into an expansion; nothing is pushed to the scoreboard.
    @(negedge clk);
    bus.set_v_i = 1'b1; bus.type_i = eS; bus.angle_i = 2'd1;
    bus.pos_v_i = 1'b1; bus.pos_i = pt(7, 7);
    @(negedge clk);
    bus.set_v_i = 1'b0; bus.pos_v_i = 1'b0;
    check("abort_busy", 64'(bus.is_ready_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset("abort");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    request(1'b1, eO, 2'd0, 1'b1, pt(2, 3), 1'b0,
            mk("post_reset", eO, 2'd0, pt(2, 3), 1'b1, 1'b0, pt(2, 3), pt(3, 3), pt(2, 4), pt(3, 4)));

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
